// File: rtl/ex_operand_stage.sv
// ex_operand_stage
//   ID/EX pipeline register plus execute-stage operand selection.
//   Captures decoded ID fields, forwards MEM/WB results onto rs/rt,
//   builds ALU operands a/b/aluc and the store data, and flags a
//   load-use hazard so upstream can hold ID while a bubble is inserted.
//
// Ports
//   clock, resetn        : rising-edge clock, async active-low reset
//   stall                : freeze all stage state
//   flush                : replace incoming ID instruction with a bubble
//   id_*                 : decoded fields from ID
//   mem_*, wb_*          : forwarding sources (MEM beats WB)
//   ex_a, ex_b, ex_aluc  : ALU operands / control
//   ex_store_data        : forwarded rt for stores
//   ex_valid, ex_wreg, ex_rn, ex_m2reg, ex_wmem : EX-stage control
//   load_use             : EX load feeds an ID source; hold ID

// One forwarding mux per source operand.
module ex_fwd_mux #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic [RW-1:0] num,
  input  logic [DW-1:0] reg_data,
  input  logic          mem_wreg,
  input  logic          mem_m2reg,
  input  logic [RW-1:0] mem_rn,
  input  logic [DW-1:0] mem_alu,
  input  logic          wb_wreg,
  input  logic [RW-1:0] wb_rn,
  input  logic [DW-1:0] wb_data,
  output logic [DW-1:0] fwd_data
);
  // A MEM load has no data yet (that is the load-use case), so only
  // non-load MEM results forward. r0 is hardwired and never forwarded.
  always_comb begin
    fwd_data = reg_data;
    if (mem_wreg && !mem_m2reg && (mem_rn != '0) && (mem_rn == num))
      fwd_data = mem_alu;
    else if (wb_wreg && (wb_rn != '0) && (wb_rn == num))
      fwd_data = wb_data;
  end
endmodule

module ex_operand_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          stall,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs_num,
  input  logic [RW-1:0] id_rt_num,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [4:0]    id_sa,
  input  logic [3:0]    id_aluc,
  input  logic          id_aluimm,
  input  logic          id_shift,
  input  logic          id_wreg,
  input  logic [RW-1:0] id_rn,
  input  logic          id_m2reg,
  input  logic          id_wmem,
  input  logic          mem_wreg,
  input  logic [RW-1:0] mem_rn,
  input  logic          mem_m2reg,
  input  logic [DW-1:0] mem_alu,
  input  logic          wb_wreg,
  input  logic [RW-1:0] wb_rn,
  input  logic [DW-1:0] wb_data,
  output logic [DW-1:0] ex_a,
  output logic [DW-1:0] ex_b,
  output logic [3:0]    ex_aluc,
  output logic [DW-1:0] ex_store_data,
  output logic          ex_valid,
  output logic          ex_wreg,
  output logic [RW-1:0] ex_rn,
  output logic          ex_m2reg,
  output logic          ex_wmem,
  output logic          load_use
);

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rs_num;
    logic [RW-1:0] rt_num;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic [4:0]    sa;
    logic [3:0]    aluc;
    logic          aluimm;
    logic          shift;
    logic          wreg;
    logic [RW-1:0] rn;
    logic          m2reg;
    logic          wmem;
  } ex_reg_t;

  ex_reg_t ex_d, ex_q;

  // Hazard is raised regardless of id_valid; upstream qualifies it.
  assign load_use = ex_q.valid && ex_q.m2reg && (ex_q.rn != '0) &&
                    ((ex_q.rn == id_rs_num) || (ex_q.rn == id_rt_num));

  always_comb begin
    ex_d = ex_q;
    if (stall) begin
      ex_d = ex_q;
    end else if (flush || load_use) begin
      // All-zero bubble: rs/rt numbers of 0 can never match forwarding.
      ex_d = '0;
    end else begin
      ex_d.valid   = id_valid;
      ex_d.rs_num  = id_rs_num;
      ex_d.rt_num  = id_rt_num;
      ex_d.rs_data = id_rs_data;
      ex_d.rt_data = id_rt_data;
      ex_d.imm     = id_imm;
      ex_d.sa      = id_sa;
      ex_d.aluc    = id_aluc;
      ex_d.aluimm  = id_aluimm;
      ex_d.shift   = id_shift;
      ex_d.wreg    = id_wreg;
      ex_d.rn      = id_rn;
      ex_d.m2reg   = id_m2reg;
      ex_d.wmem    = id_wmem;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) ex_q <= '0;
    else         ex_q <= ex_d;
  end

  // Source operands: index 0 = rs, 1 = rt.
  logic [1:0][RW-1:0] src_num;
  logic [1:0][DW-1:0] src_data;
  logic [1:0][DW-1:0] fwd_data;

  assign src_num  = {ex_q.rt_num,  ex_q.rs_num};
  assign src_data = {ex_q.rt_data, ex_q.rs_data};

  for (genvar g = 0; g < 2; g++) begin : g_fwd
    ex_fwd_mux #(.DW(DW), .RW(RW)) u_fwd (
      .num      (src_num[g]),
      .reg_data (src_data[g]),
      .mem_wreg (mem_wreg),
      .mem_m2reg(mem_m2reg),
      .mem_rn   (mem_rn),
      .mem_alu  (mem_alu),
      .wb_wreg  (wb_wreg),
      .wb_rn    (wb_rn),
      .wb_data  (wb_data),
      .fwd_data (fwd_data[g])
    );
  end

  assign ex_a          = ex_q.shift  ? {{(DW-5){1'b0}}, ex_q.sa} : fwd_data[0];
  assign ex_b          = ex_q.aluimm ? ex_q.imm : fwd_data[1];
  assign ex_store_data = fwd_data[1];
  assign ex_aluc       = ex_q.aluc;
  assign ex_valid      = ex_q.valid;
  assign ex_rn         = ex_q.rn;
  assign ex_wreg       = ex_q.wreg  & ex_q.valid;
  assign ex_m2reg      = ex_q.m2reg & ex_q.valid;
  assign ex_wmem       = ex_q.wmem  & ex_q.valid;

endmodule

// File: tb/tb_ex_operand_stage.sv
module tb_ex_operand_stage;

  logic        clock = 1'b0;
  logic        resetn, stall, flush;
  logic        id_valid;
  logic [4:0]  id_rs_num, id_rt_num, id_rn, id_sa;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [3:0]  id_aluc;
  logic        id_aluimm, id_shift, id_wreg, id_m2reg, id_wmem;
  logic        mem_wreg, mem_m2reg, wb_wreg;
  logic [4:0]  mem_rn, wb_rn;
  logic [31:0] mem_alu, wb_data;
  logic [31:0] ex_a, ex_b, ex_store_data;
  logic [3:0]  ex_aluc;
  logic        ex_valid, ex_wreg, ex_m2reg, ex_wmem, load_use;
  logic [4:0]  ex_rn;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  ex_operand_stage #(.DW(32), .RW(5)) dut (
    .clock(clock), .resetn(resetn), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_rs_num(id_rs_num), .id_rt_num(id_rt_num),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_sa(id_sa), .id_aluc(id_aluc), .id_aluimm(id_aluimm),
    .id_shift(id_shift), .id_wreg(id_wreg), .id_rn(id_rn),
    .id_m2reg(id_m2reg), .id_wmem(id_wmem),
    .mem_wreg(mem_wreg), .mem_rn(mem_rn), .mem_m2reg(mem_m2reg),
    .mem_alu(mem_alu), .wb_wreg(wb_wreg), .wb_rn(wb_rn), .wb_data(wb_data),
    .ex_a(ex_a), .ex_b(ex_b), .ex_aluc(ex_aluc),
    .ex_store_data(ex_store_data), .ex_valid(ex_valid), .ex_wreg(ex_wreg),
    .ex_rn(ex_rn), .ex_m2reg(ex_m2reg), .ex_wmem(ex_wmem),
    .load_use(load_use)
  );

  // Reference: the instruction currently sitting in EX, as the ISA sees it.
  typedef struct {
    bit        v;
    bit [4:0]  rs, rt, sa, rn;
    bit [31:0] rsd, rtd, imm;
    bit [3:0]  aluc;
    bit        aluimm, shift, wreg, m2reg, wmem;
  } instr_t;

  instr_t m;

  function automatic instr_t bubble();
    instr_t b;
    b.v = 0; b.rs = 0; b.rt = 0; b.sa = 0; b.rn = 0;
    b.rsd = 0; b.rtd = 0; b.imm = 0; b.aluc = 0;
    b.aluimm = 0; b.shift = 0; b.wreg = 0; b.m2reg = 0; b.wmem = 0;
    return b;
  endfunction

  // Newest producer of register r wins; r0 always reads the regfile copy.
  function automatic bit [31:0] src_value(bit [4:0] r, bit [31:0] rf);
    if (r == 0) return rf;
    if (mem_wreg && !mem_m2reg && mem_rn == r) return mem_alu;
    if (wb_wreg && wb_rn == r) return wb_data;
    return rf;
  endfunction

  function automatic bit model_lu();
    return m.v && m.m2reg && m.rn != 0 && (m.rn == id_rs_num || m.rn == id_rt_num);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    if (!resetn) m = bubble();
    chk({tag, ".a"},     ex_a,          m.shift ? {27'd0, m.sa} : src_value(m.rs, m.rsd));
    chk({tag, ".b"},     ex_b,          m.aluimm ? m.imm : src_value(m.rt, m.rtd));
    chk({tag, ".st"},    ex_store_data, src_value(m.rt, m.rtd));
    chk({tag, ".aluc"},  {28'd0, ex_aluc}, {28'd0, m.aluc});
    chk({tag, ".valid"}, {31'd0, ex_valid}, {31'd0, m.v});
    chk({tag, ".wreg"},  {31'd0, ex_wreg},  {31'd0, m.v & m.wreg});
    chk({tag, ".m2reg"}, {31'd0, ex_m2reg}, {31'd0, m.v & m.m2reg});
    chk({tag, ".wmem"},  {31'd0, ex_wmem},  {31'd0, m.v & m.wmem});
    chk({tag, ".rn"},    {27'd0, ex_rn},    {27'd0, m.rn});
    chk({tag, ".lu"},    {31'd0, load_use}, {31'd0, model_lu()});
  endtask

  // Advance one clock and apply the pipeline rules to the model.
  task automatic tick();
    bit lu;
    lu = model_lu();
    @(posedge clock);
    if (!resetn) m = bubble();
    else if (stall) ;
    else if (flush || lu) m = bubble();
    else begin
      m.v = id_valid; m.rs = id_rs_num; m.rt = id_rt_num;
      m.rsd = id_rs_data; m.rtd = id_rt_data; m.imm = id_imm;
      m.sa = id_sa; m.aluc = id_aluc; m.aluimm = id_aluimm;
      m.shift = id_shift; m.wreg = id_wreg; m.rn = id_rn;
      m.m2reg = id_m2reg; m.wmem = id_wmem;
    end
    #1;
  endtask

  task automatic step(string tag);
    #1;
    check_all(tag);
    tick();
  endtask

  task automatic id_clear();
    id_valid = 0; id_rs_num = 0; id_rt_num = 0; id_rs_data = 0;
    id_rt_data = 0; id_imm = 0; id_sa = 0; id_aluc = 0; id_aluimm = 0;
    id_shift = 0; id_wreg = 0; id_rn = 0; id_m2reg = 0; id_wmem = 0;
  endtask

  task automatic fwd_clear();
    mem_wreg = 0; mem_rn = 0; mem_m2reg = 0; mem_alu = 0;
    wb_wreg = 0; wb_rn = 0; wb_data = 0;
  endtask

  task automatic id_rand();
    id_valid = ($urandom_range(0, 3) != 0);
    id_rs_num = 5'($urandom_range(0, 7)); id_rt_num = 5'($urandom_range(0, 7));
    id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
    id_sa = 5'($urandom); id_aluc = 4'($urandom);
    id_aluimm = 1'($urandom); id_shift = ($urandom_range(0, 4) == 0);
    id_wreg = 1'($urandom); id_rn = 5'($urandom_range(0, 7));
    id_m2reg = ($urandom_range(0, 2) == 0); id_wmem = ($urandom_range(0, 3) == 0);
  endtask

  initial begin
    m = bubble();
    resetn = 0; stall = 0; flush = 0;
    id_clear(); fwd_clear();

    // Reset and release
    repeat (2) @(posedge clock);
    #2 resetn = 1;
    #1 check_all("reset");
    chk("reset.a0", ex_a, 32'd0);
    chk("reset.lu0", {31'd0, load_use}, 32'd0);

    // add r3,r1,r2
    id_valid = 1; id_rs_num = 1; id_rt_num = 2; id_rs_data = 5; id_rt_data = 7;
    id_aluc = 4'b0000; id_wreg = 1; id_rn = 3;
    step("add_id");
    chk("add.a", ex_a, 32'd5);
    chk("add.b", ex_b, 32'd7);
    chk("add.rn", {27'd0, ex_rn}, 32'd3);
    chk("add.wreg", {31'd0, ex_wreg}, 32'd1);

    // Forwarding with EX held
    stall = 1; id_clear();
    mem_wreg = 1; mem_rn = 1; mem_alu = 32'h100;
    wb_wreg = 1; wb_rn = 1; wb_data = 32'h200;
    #1 check_all("fwd_mem_wins");
    chk("fwd.a_mem", ex_a, 32'h100);
    chk("fwd.b_none", ex_b, 32'd7);
    wb_rn = 2; wb_data = 32'h33;
    #1 check_all("fwd_wb_rt");
    chk("fwd.b_wb", ex_b, 32'h33);
    mem_rn = 0; wb_rn = 0;
    #1 check_all("fwd_r0");
    chk("fwd.a_r0", ex_a, 32'd5);
    chk("fwd.b_r0", ex_b, 32'd7);
    tick();

    // Load-use: lw r4, then consumer reading r4
    stall = 0; fwd_clear();
    id_valid = 1; id_m2reg = 1; id_wreg = 1; id_rn = 4; id_rs_num = 0;
    step("lw_id");
    id_clear(); id_valid = 1; id_rs_num = 4; id_rt_num = 6; id_wreg = 1; id_rn = 5;
    #1 chk("lu.hit", {31'd0, load_use}, 32'd1);
    step("lu_cycle");
    chk("lu.bubble_v", {31'd0, ex_valid}, 32'd0);
    chk("lu.bubble_w", {31'd0, ex_wreg}, 32'd0);
    wb_wreg = 1; wb_rn = 4; wb_data = 32'hABCD;
    step("lu_retry");
    chk("lu.wb_fwd", ex_a, 32'hABCD);
    fwd_clear();

    // sll held by stall, then flush
    id_clear(); id_valid = 1; id_shift = 1; id_sa = 3; id_wreg = 1; id_rn = 7;
    step("sll_id");
    stall = 1;
    for (int i = 0; i < 2; i++) begin
      id_rand();
      step("sll_stall");
      chk("sll.a_hold", ex_a, 32'd3);
    end
    stall = 0; flush = 1;
    step("flush");
    chk("flush.v", {31'd0, ex_valid}, 32'd0);
    flush = 0; id_clear(); id_valid = 1; id_wreg = 1; id_rn = 2;
    step("reload");
    flush = 1; stall = 1;
    step("flush_stall");
    chk("flush_stall.v", {31'd0, ex_valid}, 32'd1);
    flush = 0; stall = 0;

    // Asynchronous reset mid-cycle while EX holds a valid instruction
    #2 resetn = 0;
    #1 chk("arst.v", {31'd0, ex_valid}, 32'd0);
    chk("arst.w", {31'd0, ex_wreg}, 32'd0);
    check_all("arst");
    #1 resetn = 1;
    tick();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      id_rand();
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 9) == 0);
      mem_wreg = 1'($urandom); mem_m2reg = ($urandom_range(0, 3) == 0);
      mem_rn = 5'($urandom_range(0, 7)); mem_alu = $urandom;
      wb_wreg = 1'($urandom); wb_rn = 5'($urandom_range(0, 7)); wb_data = $urandom;
      resetn = ($urandom_range(0, 49) != 0);
      step("rand");
      resetn = 1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
